// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: pipeline/MDU request and register-write bus of the writeback arbiter
interface wb_write_arbiter_if #(
  parameter int DBITS      = 32,
  parameter int REGNOBITS  = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic                 pipe_valid;
  logic [REGNOBITS-1:0] pipe_regno;
  logic [DBITS-1:0]     pipe_value;
  logic                 pipe_stall;
  logic                 mdu_valid;
  logic [REGNOBITS-1:0] mdu_regno;
  logic [DBITS-1:0]     mdu_value;
  logic                 mdu_ready;
  logic                 wr_reg_WB;
  logic [REGNOBITS-1:0] wregno_WB;
  logic [DBITS-1:0]     regval_WB;
  logic [CW-1:0]        fifo_count;
  logic                 starve_active;
  modport master (
    output pipe_valid, pipe_regno, pipe_value, mdu_valid, mdu_regno, mdu_value,
    input  pipe_stall, mdu_ready, wr_reg_WB, wregno_WB, regval_WB, fifo_count, starve_active
  );
  modport slave (
    input  pipe_valid, pipe_regno, pipe_value, mdu_valid, mdu_regno, mdu_value,
    output pipe_stall, mdu_ready, wr_reg_WB, wregno_WB, regval_WB, fifo_count, starve_active
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between pipeline writeback and a buffered MDU
module wb_write_arbiter #(
  parameter int DBITS        = 32,
  parameter int REGNOBITS    = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  wb_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [REGNOBITS-1:0] regno_mem [FIFO_DEPTH];
  logic [DBITS-1:0]     value_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_cnt;
  logic                 fifo_ne, starve, ready, push, pop, grant_pipe, grant;
  logic [REGNOBITS-1:0] g_regno, regno_q;
  logic [DBITS-1:0]     g_value, value_q;
  logic                 wr_q;
  // Grant selection: a forced MDU slot beats the pipeline, which beats an unforced MDU slot
  always_comb begin
    fifo_ne    = count != '0;
    starve     = (starve_cnt == LIMIT) && fifo_ne;
    ready      = count < DEPTH;
    push       = bus.mdu_valid && ready;
    grant_pipe = bus.pipe_valid && !starve;
    pop        = fifo_ne && !grant_pipe;
    grant      = grant_pipe || pop;
    g_regno    = pop ? regno_mem[rd_ptr] : bus.pipe_regno;
    g_value    = pop ? value_mem[rd_ptr] : bus.pipe_value;
  end
  assign bus.mdu_ready     = ready;
  assign bus.pipe_stall    = bus.pipe_valid && starve;
  assign bus.starve_active = starve;
  assign bus.fifo_count    = count;
  assign bus.wr_reg_WB     = wr_q;
  assign bus.wregno_WB     = regno_q;
  assign bus.regval_WB     = value_q;
  // MDU result storage; contents are meaningless outside the pointer window so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      regno_mem[wr_ptr] <= bus.mdu_regno;
      value_mem[wr_ptr] <= bus.mdu_value;
    end
  end
  // FIFO pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Counts cycles a waiting MDU result is passed over, saturating at the forcing threshold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_cnt <= '0;
    else if (!fifo_ne || pop) starve_cnt <= '0;
    else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + SW'(1);
  end
  // Registered write port; x0 requests are consumed but never enable a write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      regno_q <= '0;
      value_q <= '0;
    end else begin
      wr_q <= grant && (g_regno != '0);
      if (grant) begin
        regno_q <= g_regno;
        value_q <= g_value;
      end
    end
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Arbitrates the single register-file write port between two sources: the in-order pipeline writeback and a long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO. The pipeline has priority, and a starvation counter periodically forces an MDU slot.
- Sits between the MEM/WB boundary and the write-port fields sent to the DE stage.
- Produces registered write-enable, destination register number and write value.

Parameters:
DBITS, 32, data width of register values
REGNOBITS, 5, register number width
FIFO_DEPTH, 2, MDU result buffer entries (power of 2, >=2)
STARVE_LIMIT, 4, cycles a non-empty FIFO may be bypassed before a forced MDU grant (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
pipe_valid  in  1  pipeline writeback request this cycle
pipe_regno  in  REGNOBITS  pipeline destination register
pipe_value  in  DBITS  pipeline write value
pipe_stall  out  1  pipeline request not taken; pipeline must hold its request
mdu_valid  in  1  MDU result available
mdu_regno  in  REGNOBITS  MDU destination register
mdu_value  in  DBITS  MDU result value
mdu_ready  out  1  FIFO can accept an MDU result this cycle
wr_reg_WB  out  1  register write enable (registered)
wregno_WB  out  REGNOBITS  destination register (registered)
regval_WB  out  DBITS  write value (registered)
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
starve_active  out  1  forced MDU grant in effect this cycle

Behaviour:
- Reset (reset==0, asynchronous, any time):
  - wr_reg_WB, wregno_WB and regval_WB are 0.
  - FIFO is emptied (pointers and count 0) and the starvation counter is cleared.
  - Entries in flight when reset asserts mid-operation are discarded.
- Enqueue:
  - An entry is enqueued when mdu_valid && mdu_ready.
  - mdu_ready = (fifo_count < FIFO_DEPTH), derived from registered count only.
  - A same-cycle dequeue does not make a full FIFO ready.
- starve_active = (starve_cnt == STARVE_LIMIT) && (fifo_count != 0). Combinational.
- Grant priority each cycle (combinational):
  - starve_active: grant the FIFO head. pipe_stall = pipe_valid.
  - else if pipe_valid: grant the pipeline. pipe_stall = 0.
  - else if fifo_count != 0: grant the FIFO head.
  - else: no grant.
- Dequeue: the FIFO head is popped in any cycle it is granted.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance, with wrap-around modulo FIFO_DEPTH.
- An empty FIFO is never popped. An enqueue into an empty FIFO is not granted in the same cycle; minimum enqueue-to-write latency is 1 cycle to the FIFO plus 1 cycle to the outputs.
- Output register, updated on the next rising edge after a grant:
  - wregno_WB and regval_WB load the granted source's fields.
  - wr_reg_WB = 1 unless the granted regno is 0. A regno-0 request is still consumed (popped or accepted) but produces wr_reg_WB = 0.
  - With no grant, wr_reg_WB = 0 and wregno_WB/regval_WB hold their previous values.
  - Latency: a grant in cycle N gives a visible write in cycle N+1.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle with fifo_count != 0 and no FIFO grant.
  - Clears to 0 on a FIFO grant or when fifo_count == 0.
- A pipeline request under pipe_stall is not captured. The requester holds pipe_valid, pipe_regno and pipe_value until a cycle without stall.
- Ordering between pipeline and MDU writes to the same register is the issue logic's responsibility and is not checked here.
- fifo_count is the registered occupancy, range 0..FIFO_DEPTH.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill the FIFO with 2 entries, assert reset=0 for 1 cycle, release.
  - Required: fifo_count = 0, wr_reg_WB = 0, mdu_ready = 1 immediately after reset asserts.
- Pipeline only:
  - Stimulus: pipe_valid = 1, regno 5, value 0xDEADBEEF in cycle N.
  - Required: cycle N+1 shows wr_reg_WB = 1, wregno_WB = 5, regval_WB = 0xDEADBEEF; pipe_stall = 0 throughout.
- MDU only:
  - Stimulus: mdu_valid = 1, regno 7, value 0x12 in cycle N; pipe idle.
  - Required: fifo_count = 1 in N+1, write of x7 = 0x12 visible in N+2, fifo_count = 0 in N+2.
- Starvation with STARVE_LIMIT = 4:
  - Stimulus: one queued MDU entry, pipe_valid held continuously.
  - Required: 4 pipeline writes, then starve_active = 1 and pipe_stall = 1 for exactly 1 cycle, MDU write visible the following cycle, then pipeline writes resume.
- Full FIFO:
  - Stimulus: 3 back-to-back MDU results with pipe busy.
  - Required: mdu_ready = 0 after 2 enqueues; third result accepted only after a pop; values written out in FIFO order.
- Register x0:
  - Stimulus: pipe request with regno 0, value 0xFF.
  - Required: wr_reg_WB = 0 next cycle, no stall; queued MDU entry with regno 0 is popped with wr_reg_WB = 0.
